// File: rtl/smart_traffic_light_ctrl.sv
// Demand-actuated controller for one main/secondary intersection with protected left turn,
// pedestrian phase, yellow/all-red clearance and emergency preemption on both approaches.
//
// state | meaning
// MG    | main through green
// MY    | main yellow
// ML    | main protected left arrow
// LY    | left-arrow yellow
// SG    | secondary green
// SY    | secondary yellow
// PED   | pedestrian walk
// AR    | all-red clearance, picks the next phase on exit
module smart_traffic_light_ctrl #(
    parameter int CNT_W     = 3,
    parameter int TMR_W     = 8,
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 24,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 2,
    parameter int LEFT_T    = 6,
    parameter int PED_T     = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] main_num,
    input  logic [CNT_W-1:0] left_num,
    input  logic [CNT_W-1:0] sec_num,
    input  logic [CNT_W-1:0] p_num,
    input  logic             m_emergency,
    input  logic             s_emergency,
    output logic [3:0]       m_LRYG,
    output logic [2:0]       s_RYG,
    output logic             p,
    output logic [3:0]       phase,
    output logic             preempt
);

    typedef enum logic [3:0] {
        MG  = 4'd0,
        MY  = 4'd1,
        ML  = 4'd2,
        LY  = 4'd3,
        SG  = 4'd4,
        SY  = 4'd5,
        PED = 4'd6,
        AR  = 4'd7
    } state_t;

    typedef enum logic [1:0] {
        SRV_MG  = 2'd0,
        SRV_ML  = 2'd1,
        SRV_SG  = 2'd2,
        SRV_PED = 2'd3
    } srv_t;

    localparam logic [TMR_W-1:0] MIN_LAST  = TMR_W'(MIN_GREEN - 1);
    localparam logic [TMR_W-1:0] MAX_LAST  = TMR_W'(MAX_GREEN - 1);
    localparam logic [TMR_W-1:0] YEL_LAST  = TMR_W'(YELLOW_T - 1);
    localparam logic [TMR_W-1:0] AR_LAST   = TMR_W'(ALLRED_T - 1);
    localparam logic [TMR_W-1:0] LEFT_LAST = TMR_W'(LEFT_T - 1);
    localparam logic [TMR_W-1:0] PED_LAST  = TMR_W'(PED_T - 1);

    state_t           state, state_nxt, svc_state;
    srv_t             last_served, last_nxt;
    logic [TMR_W-1:0] timer;
    logic             demand;
    logic [3:0]       m_lamp_nxt;
    logic [2:0]       s_lamp_nxt;
    logic             p_nxt;

    assign demand = (left_num != '0) || (sec_num != '0) || (p_num != '0);

    // Service order does not wrap: after PED the only choice is MG.
    always_comb begin
        svc_state = MG;
        case (last_served)
            SRV_MG: begin
                if (left_num != '0)     svc_state = ML;
                else if (sec_num != '0) svc_state = SG;
                else if (p_num != '0)   svc_state = PED;
            end
            SRV_ML: begin
                if (sec_num != '0)      svc_state = SG;
                else if (p_num != '0)   svc_state = PED;
            end
            SRV_SG: begin
                if (p_num != '0)        svc_state = PED;
            end
            default: svc_state = MG;
        endcase
    end

    always_comb begin
        state_nxt = state;
        last_nxt  = last_served;
        case (state)
            MG: begin
                if (!m_emergency && (s_emergency || (demand &&
                    ((timer >= MIN_LAST && main_num == '0) || timer >= MAX_LAST))))
                    state_nxt = MY;
            end
            MY: begin
                if (timer == YEL_LAST) begin
                    state_nxt = AR;
                    last_nxt  = SRV_MG;
                end
            end
            ML: begin
                if (m_emergency || s_emergency || timer == LEFT_LAST)
                    state_nxt = LY;
            end
            LY: begin
                if (timer == YEL_LAST) begin
                    state_nxt = AR;
                    last_nxt  = SRV_ML;
                end
            end
            SG: begin
                if (m_emergency || (!s_emergency &&
                    ((timer >= MIN_LAST && sec_num == '0) || timer >= MAX_LAST)))
                    state_nxt = SY;
            end
            SY: begin
                if (timer == YEL_LAST) begin
                    state_nxt = AR;
                    last_nxt  = SRV_SG;
                end
            end
            PED: begin
                if (m_emergency || s_emergency || timer == PED_LAST) begin
                    state_nxt = AR;
                    last_nxt  = SRV_PED;
                end
            end
            AR: begin
                if (timer == AR_LAST) begin
                    if (m_emergency)      state_nxt = MG;
                    else if (s_emergency) state_nxt = SG;
                    else                  state_nxt = svc_state;
                end
            end
            default: state_nxt = MG;
        endcase
    end

    // Lamps are decoded from the next state so they register on the transition edge.
    always_comb begin
        m_lamp_nxt = 4'b0100;
        s_lamp_nxt = 3'b100;
        p_nxt      = 1'b0;
        case (state_nxt)
            MG:      m_lamp_nxt = 4'b0001;
            MY:      m_lamp_nxt = 4'b0010;
            ML:      m_lamp_nxt = 4'b1100;
            LY:      m_lamp_nxt = 4'b0110;
            SG:      s_lamp_nxt = 3'b001;
            SY:      s_lamp_nxt = 3'b010;
            PED:     p_nxt      = 1'b1;
            default: m_lamp_nxt = 4'b0100;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= MG;
            last_served <= SRV_MG;
            timer       <= '0;
            preempt     <= 1'b0;
            m_LRYG      <= 4'b0001;
            s_RYG       <= 3'b100;
            p           <= 1'b0;
        end else begin
            state       <= state_nxt;
            last_served <= last_nxt;
            preempt     <= m_emergency | s_emergency;
            m_LRYG      <= m_lamp_nxt;
            s_RYG       <= s_lamp_nxt;
            p           <= p_nxt;
            if (state_nxt != state)
                timer <= '0;
            else if (timer != '1)
                timer <= timer + TMR_W'(1);
        end
    end

    assign phase = state;

endmodule

// File: tb/tb_smart_traffic_light_ctrl.sv
// Directed bench for smart_traffic_light_ctrl: phase sequences, lamp decode, preemption and reset.
module tb_smart_traffic_light_ctrl;

    logic       clk;
    logic       rst;
    logic [2:0] main_num, left_num, sec_num, p_num;
    logic       m_emergency, s_emergency;
    logic [3:0] m_LRYG;
    logic [2:0] s_RYG;
    logic       p;
    logic [3:0] phase;
    logic       preempt;

    int checks   = 0;
    int failures = 0;

    smart_traffic_light_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .main_num    (main_num),
        .left_num    (left_num),
        .sec_num     (sec_num),
        .p_num       (p_num),
        .m_emergency (m_emergency),
        .s_emergency (s_emergency),
        .m_LRYG      (m_LRYG),
        .s_RYG       (s_RYG),
        .p           (p),
        .phase       (phase),
        .preempt     (preempt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected {m_LRYG, s_RYG, p} for each phase code.
    function automatic logic [7:0] lamp_of(input logic [3:0] code);
        case (code)
            4'd0:    return 8'b0001_100_0;
            4'd1:    return 8'b0010_100_0;
            4'd2:    return 8'b1100_100_0;
            4'd3:    return 8'b0110_100_0;
            4'd4:    return 8'b0100_001_0;
            4'd5:    return 8'b0100_010_0;
            4'd6:    return 8'b0100_100_1;
            default: return 8'b0100_100_0;
        endcase
    endfunction

    task automatic hold_reset();
        rst         = 1'b0;
        main_num    = '0;
        left_num    = '0;
        sec_num     = '0;
        p_num       = '0;
        m_emergency = 1'b0;
        s_emergency = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst         = 1'b0;
        m_emergency = 1'b1;
        s_emergency = 1'b1;
        sec_num     = 3'd4;
        main_num    = '0;
        left_num    = '0;
        p_num       = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (phase !== 4'd0 || {m_LRYG, s_RYG, p} !== 8'b0001_100_0 || preempt !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold phase=%0d lamps=%b preempt=%b expected phase=0 lamps=00011000 preempt=0",
                     phase, {m_LRYG, s_RYG, p}, preempt);
        end
        hold_reset();
        rst = 1'b1;
        for (int k = 0; k < 100; k++) begin
            checks++;
            if (phase !== 4'd0 || {m_LRYG, s_RYG, p} !== 8'b0001_100_0) begin
                failures++;
                $display("FAIL idle cyc=%0d phase=%0d lamps=%b expected phase=0 lamps=00011000",
                         k, phase, {m_LRYG, s_RYG, p});
            end
            @(negedge clk);
        end
    endtask

    task automatic test_sec_only();
        int codes [7] = '{0, 1, 7, 4, 5, 7, 0};
        int lens  [7] = '{8, 3, 2, 24, 3, 2, 1};
        logic [3:0] ep;
        hold_reset();
        sec_num = 3'd4;
        rst     = 1'b1;
        for (int s = 0; s < 7; s++) begin
            ep = codes[s][3:0];
            for (int k = 0; k < lens[s]; k++) begin
                checks++;
                if (phase !== ep || {m_LRYG, s_RYG, p} !== lamp_of(ep)) begin
                    failures++;
                    $display("FAIL sec_only seg=%0d cyc=%0d phase=%0d lamps=%b expected phase=%0d lamps=%b",
                             s, k, phase, {m_LRYG, s_RYG, p}, ep, lamp_of(ep));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_max_and_gapout();
        int codes [7] = '{0, 1, 7, 4, 5, 7, 0};
        int lens  [7] = '{24, 3, 2, 8, 3, 2, 1};
        logic [3:0] ep;
        hold_reset();
        main_num = 3'd4;
        sec_num  = 3'd2;
        rst      = 1'b1;
        for (int s = 0; s < 7; s++) begin
            ep = codes[s][3:0];
            for (int k = 0; k < lens[s]; k++) begin
                checks++;
                if (phase !== ep || {m_LRYG, s_RYG, p} !== lamp_of(ep)) begin
                    failures++;
                    $display("FAIL max_gapout seg=%0d cyc=%0d phase=%0d lamps=%b expected phase=%0d lamps=%b",
                             s, k, phase, {m_LRYG, s_RYG, p}, ep, lamp_of(ep));
                end
                if (s == 3 && k == 0) sec_num = '0;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_left_ped();
        int codes [9] = '{0, 1, 7, 2, 3, 7, 6, 7, 0};
        int lens  [9] = '{8, 3, 2, 6, 3, 2, 10, 2, 1};
        logic [3:0] ep;
        hold_reset();
        left_num = 3'd2;
        p_num    = 3'd2;
        rst      = 1'b1;
        for (int s = 0; s < 9; s++) begin
            ep = codes[s][3:0];
            for (int k = 0; k < lens[s]; k++) begin
                checks++;
                if (phase !== ep || {m_LRYG, s_RYG, p} !== lamp_of(ep)) begin
                    failures++;
                    $display("FAIL left_ped seg=%0d cyc=%0d phase=%0d lamps=%b expected phase=%0d lamps=%b",
                             s, k, phase, {m_LRYG, s_RYG, p}, ep, lamp_of(ep));
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic test_s_preempt();
        int codes [7] = '{0, 1, 7, 4, 5, 7, 0};
        int lens  [7] = '{4, 3, 2, 13, 3, 2, 1};
        logic [3:0] ep;
        logic       epr;
        hold_reset();
        rst = 1'b1;
        for (int s = 0; s < 7; s++) begin
            ep  = codes[s][3:0];
            epr = (s >= 1 && s <= 3);
            for (int k = 0; k < lens[s]; k++) begin
                checks++;
                if (phase !== ep || {m_LRYG, s_RYG, p} !== lamp_of(ep) || preempt !== epr) begin
                    failures++;
                    $display("FAIL s_preempt seg=%0d cyc=%0d phase=%0d lamps=%b preempt=%b expected phase=%0d lamps=%b preempt=%b",
                             s, k, phase, {m_LRYG, s_RYG, p}, preempt, ep, lamp_of(ep), epr);
                end
                if (s == 0 && k == 3)  s_emergency = 1'b1;
                if (s == 3 && k == 12) s_emergency = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_back_to_back_preempt();
        int codes [10] = '{0, 1, 7, 4, 5, 7, 0, 1, 7, 4};
        int lens  [10] = '{8, 3, 2, 3, 3, 2, 13, 3, 2, 4};
        logic [3:0] ep;
        logic       epr;
        hold_reset();
        sec_num = 3'd4;
        rst     = 1'b1;
        for (int s = 0; s < 10; s++) begin
            ep  = codes[s][3:0];
            epr = (s >= 4);
            for (int k = 0; k < lens[s]; k++) begin
                checks++;
                if (phase !== ep || {m_LRYG, s_RYG, p} !== lamp_of(ep) || preempt !== epr) begin
                    failures++;
                    $display("FAIL dual_preempt seg=%0d cyc=%0d phase=%0d lamps=%b preempt=%b expected phase=%0d lamps=%b preempt=%b",
                             s, k, phase, {m_LRYG, s_RYG, p}, preempt, ep, lamp_of(ep), epr);
                end
                if (s == 3 && k == 2) begin
                    m_emergency = 1'b1;
                    s_emergency = 1'b1;
                end
                if (s == 6 && k == 12) m_emergency = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset_mid();
        rst = 1'b0;
        #1;
        checks++;
        if (phase !== 4'd0 || {m_LRYG, s_RYG, p} !== 8'b0001_100_0 || preempt !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid phase=%0d lamps=%b preempt=%b expected phase=0 lamps=00011000 preempt=0",
                     phase, {m_LRYG, s_RYG, p}, preempt);
        end
        hold_reset();
    endtask

    task automatic test_m_preempt_ped();
        int codes [7] = '{0, 1, 7, 6, 7, 0, 1};
        int lens  [7] = '{8, 3, 2, 4, 2, 10, 1};
        logic [3:0] ep;
        logic       epr;
        hold_reset();
        p_num = 3'd2;
        rst   = 1'b1;
        for (int s = 0; s < 7; s++) begin
            ep  = codes[s][3:0];
            epr = (s == 4 || s == 5);
            for (int k = 0; k < lens[s]; k++) begin
                checks++;
                if (phase !== ep || {m_LRYG, s_RYG, p} !== lamp_of(ep) || preempt !== epr) begin
                    failures++;
                    $display("FAIL m_preempt_ped seg=%0d cyc=%0d phase=%0d lamps=%b preempt=%b expected phase=%0d lamps=%b preempt=%b",
                             s, k, phase, {m_LRYG, s_RYG, p}, preempt, ep, lamp_of(ep), epr);
                end
                if (s == 3 && k == 3) m_emergency = 1'b1;
                if (s == 5 && k == 9) m_emergency = 1'b0;
                @(negedge clk);
            end
        end
    endtask

    initial begin
        rst         = 1'b0;
        main_num    = '0;
        left_num    = '0;
        sec_num     = '0;
        p_num       = '0;
        m_emergency = 1'b0;
        s_emergency = 1'b0;
        test_reset();
        test_sec_only();
        test_max_and_gapout();
        test_left_ped();
        test_s_preempt();
        test_back_to_back_preempt();
        test_reset_mid();
        test_m_preempt_ped();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/smart_traffic_light_ctrl.md
# smart_traffic_light_ctrl

Parametrised, demand-actuated controller for one main/secondary intersection. It has a protected main left-turn phase, a pedestrian phase, yellow and all-red clearance intervals, and emergency preemption on both approaches. It sits directly behind the per-approach vehicle/pedestrian queue counters. It drives the main (L/R/Y/G), secondary (R/Y/G) and pedestrian lamp outputs as registered Moore outputs.

## Interface
- CNT_W, 3: width of each queue-count input (unsigned; 0 = no demand)
- TMR_W, 8: phase timer width; every duration parameter must satisfy 1 ≤ value < 2^TMR_W
- MIN_GREEN, 8: minimum main/secondary green, cycles
- MAX_GREEN, 24: maximum main/secondary green under competing demand, cycles (≥ MIN_GREEN)
- YELLOW_T, 3: yellow clearance, cycles (main, secondary and left)
- ALLRED_T, 2: all-red interval, cycles
- LEFT_T, 6: protected left-arrow duration, cycles
- PED_T, 10: pedestrian walk duration, cycles
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- main_num  in  CNT_W  main through-queue count
- left_num  in  CNT_W  main left-turn queue count
- sec_num  in  CNT_W  secondary queue count
- p_num  in  CNT_W  waiting-pedestrian count
- m_emergency  in  1  main-approach emergency request, level
- s_emergency  in  1  secondary-approach emergency request, level
- m_LRYG  out  4  main lamps {left arrow, red, yellow, green}
- s_RYG  out  3  secondary lamps {red, yellow, green}
- p  out  1  pedestrian walk
- phase  out  4  current state code (encoding below)
- preempt  out  1  high while m_emergency or s_emergency is registered active

## Operation
- States, codes and lamp outputs (m_LRYG / s_RYG / p):
  - MG=0: 0001 / 100 / 0
  - MY=1: 0010 / 100 / 0
  - ML=2: 1100 / 100 / 0
  - LY=3: 0110 / 100 / 0
  - SG=4: 0100 / 001 / 0
  - SY=5: 0100 / 010 / 0
  - PED=6: 0100 / 100 / 1
  - AR=7: 0100 / 100 / 0
- Timer: cleared to 0 on entry to any state, then increments each cycle and saturates at all-ones. A state of duration D exits on the edge after the cycle where timer == D−1.
- Competing demand while in MG: left_num|sec_num|p_num ≠ 0.
- MG exits to MY when competing demand exists and either (timer ≥ MIN_GREEN−1 and main_num == 0) or timer ≥ MAX_GREEN−1. With no competing demand, MG holds indefinitely.
- SG exits to SY when (timer ≥ MIN_GREEN−1 and sec_num == 0) or timer ≥ MAX_GREEN−1.
- Fixed-duration states:
  - MY, LY and SY last YELLOW_T, then go to AR.
  - ML lasts LEFT_T, then goes to LY.
  - PED lasts PED_T, then goes to AR.
  - AR lasts ALLRED_T.
- Service order is MG → ML → SG → PED → MG. A 2-bit "last served" register records the phase before AR. At AR exit the controller enters the first later phase in that order whose count is nonzero, sampled in the AR exit cycle. If none qualifies, it enters MG.
- Preemption is evaluated every cycle. m_emergency has priority if both requests are high.
  - m_emergency:
    - SG → SY; PED → AR.
    - ML → LY.
    - MG holds and never exits while the request is high.
    - AR exits to MG.
    - Yellows complete their normal timing.
  - s_emergency:
    - MG → MY; ML → LY; PED → AR.
    - SG holds and never exits while the request is high.
    - AR exits to SG.
  - Preemption overrides MIN_GREEN. Clearance intervals (yellow, all-red) are never shortened.
  - After the request drops, normal exit rules apply from the current timer value. The hold does not reset the timer.
- preempt is registered from (m_emergency|s_emergency).

## Timing
- Reset (rst low, asynchronous): state MG, timer 0, last-served MG, m_LRYG=0001, s_RYG=100, p=0, phase=0, preempt=0. These values hold while rst is low; operation resumes on the first rising edge after release.
- All outputs are registered and decoded from state. They change on the same edge as the state transition.
- Inputs are sampled each rising edge. Decision latency is one cycle: an input change in cycle n can change outputs at edge n+1.
- Reset mid-phase returns to MG immediately, with no yellow or all-red.

## Test plan
- Reset, all inputs 0, run 100 cycles → m_LRYG=0001, s_RYG=100, p=0, phase=0 throughout.
- sec_num=4 from reset, others 0 → MG for 8 cycles, MY 3, AR 2, SG 24 (MAX_GREEN), SY 3, AR 2, then MG.
- main_num=4, sec_num=2 → MG holds the full 24 cycles before MY. Then, if sec_num is set to 0 during SG → SG exits 8 cycles after entry.
- left_num=2, p_num=2, others 0 → sequence MG8, MY3, AR2, ML6 (m_LRYG=1100), LY3, AR2, PED10 (p=1), AR2, MG.
- s_emergency raised at MG timer=3 → MY next edge, AR, SG held while high (preempt=1). On release after MIN_GREEN with sec_num=0 → SY, AR, MG.
- m_emergency and s_emergency raised together during SG → SY, AR, MG held until m_emergency drops. Then s_emergency (still high) → MY, AR, SG.
